ddr3_reset_init_seq: RTL and testbench
======================================

Name: ddr3_reset_init_seq

Overview:
Fabric-side sequencer that generates the DDR3 power-up/reset timing for the RESET_N and CKE pins. It produces the 4-bit per-FAB_CLK lane words (TX_DATA/OE_DATA) consumed directly by the RESET_N and CKE I/O serializer stages in PF_DDR3_C0_DDRPHY_BLK. It holds RESET_N low, releases it, waits the CKE-low interval, raises CKE, then waits tXPR and flags the controller that MRS/ZQCL may begin. It also supplies static tie-offs for the RESET_N lane's delay-line controls.

Parameters:
RESET_CYCLES, 33300, FAB_CLK cycles RESET_N held low after start (200 us at 166.5 MHz); must be >= 1
CKE_CYCLES, 83250, FAB_CLK cycles from RESET_N high to CKE high (500 us); must be >= 1
XPR_CYCLES, 64, FAB_CLK cycles from CKE high to INIT_DONE (tXPR margin); must be >= 1
CNT_W, 17, timer width; must satisfy 2^CNT_W > max(RESET_CYCLES, CKE_CYCLES, XPR_CYCLES)

Ports:
FAB_CLK  input  1  fabric clock, the same clock as the I/O serializer TX_CLK
SYNC_RST  input  1  synchronous reset, active-high
START  input  1  single-cycle pulse; begins the init sequence from IDLE
RESET_REQ  input  1  single-cycle pulse; re-asserts DDR3 reset from any state
RESET_N_TX_DATA  output  4  to RESET_N serializer TX_DATA_0
RESET_N_OE_DATA  output  4  to RESET_N serializer OE_DATA_0
CKE_TX_DATA  output  4  to CKE serializer TX_DATA lane
RESET_N_DLY_MOVE  output  1  delay-line move, constant 0
RESET_N_DLY_DIR  output  1  delay-line direction, constant 0
RESET_N_DLY_LOAD  output  1  delay-line load, constant 0
BUSY  output  1  high in RST_HOLD, CKE_WAIT and XPR_WAIT
INIT_DONE  output  1  high in DONE only
STATE  output  3  encoded current state, for debug

Behaviour:
- Clock and reset: single clock FAB_CLK. Reset is synchronous and active-high on SYNC_RST.
- Reset values and IDLE: SYNC_RST forces state IDLE and timer 0.
  - RESET_N_TX_DATA=4'b0000 (RESET_N driven low); RESET_N_OE_DATA=4'b1111.
  - CKE_TX_DATA=4'b0000; BUSY=0; INIT_DONE=0; STATE=0.
- Output encoding:
  - All data outputs are registered and decoded from the next state, so they change on the same edge as STATE.
  - All 4 bits of each lane word are always identical; there are no sub-cycle transitions.
  - RESET_N_OE_DATA is constant 4'b1111 in every state, including reset. The pad is never tri-stated.
- States (STATE encoding):
  - IDLE=0: RESET_N low, CKE low. START -> RST_HOLD.
  - RST_HOLD=1: RESET_N low, CKE low. The timer counts RESET_CYCLES cycles, then -> CKE_WAIT.
  - CKE_WAIT=2: RESET_N=4'b1111, CKE low. The timer counts CKE_CYCLES cycles, then -> XPR_WAIT.
  - XPR_WAIT=3: RESET_N high, CKE_TX_DATA=4'b1111. The timer counts XPR_CYCLES cycles, then -> DONE.
  - DONE=4: RESET_N high, CKE high, INIT_DONE=1. The block holds here until RESET_REQ or SYNC_RST.
- Timing from START sampled high at edge k:
  - STATE=1 after edge k.
  - RESET_N_TX_DATA becomes 1111 after edge k+RESET_CYCLES.
  - CKE_TX_DATA becomes 1111 after edge k+RESET_CYCLES+CKE_CYCLES.
  - INIT_DONE becomes 1 after edge k+RESET_CYCLES+CKE_CYCLES+XPR_CYCLES.
- Timer:
  - Loads 0 on every state entry and increments each cycle.
  - The state exits when timer == N-1, where N is the state's cycle parameter.
  - It never wraps within a state.
- RESET_REQ:
  - In any state, it forces next state RST_HOLD with the timer reloaded.
  - RESET_N drops to 0000 and CKE to 0000 on the same edge.
  - A RESET_REQ arriving during RST_HOLD restarts the full RESET_CYCLES hold.
- Simultaneous events and priority:
  - SYNC_RST has priority over RESET_REQ, which has priority over START.
  - START is ignored outside IDLE.
  - START and RESET_REQ in the same cycle behave as RESET_REQ, which produces the same result.
- Invariant: CKE_TX_DATA is never 1111 while RESET_N_TX_DATA is 0000.

Decomposition:
- Shared package ddr3_init_pkg holds:
  - the state enum (IDLE..DONE, 3 bits);
  - the default cycle constants;
  - the lane constants LANE_LO=4'b0000 and LANE_HI=4'b1111.
- One sub-module, ddr3_init_timer: a CNT_W-bit counter with load/clear and a terminal-count compare against a runtime limit. It is shared by all timed states.

Test Plan:
All scenarios use RESET_CYCLES=8, CKE_CYCLES=12, XPR_CYCLES=4.
- Reset: assert SYNC_RST for 3 cycles mid-DONE -> next edge gives RESET_N_TX_DATA=0000, CKE=0000, OE=1111, STATE=0, INIT_DONE=0.
- Nominal sequence: START pulse at edge 10 ->
  - STATE=1 at edge 10;
  - RESET_N=1111 at edge 18;
  - CKE=1111 at edge 30;
  - INIT_DONE=1 and STATE=4 at edge 34;
  - BUSY=1 from edge 10 to 33.
- RESET_REQ during CKE_WAIT at edge 25 -> RESET_N=0000 at edge 25, STATE=1, RESET_N=1111 again at edge 33, CKE still 0000.
- RESET_REQ during RST_HOLD at edge 15 after START at edge 10 -> RESET_N stays 0000 until edge 23 (full restart).
- START and RESET_REQ together in IDLE at edge 5 -> STATE=1; a START pulse at edge 8 is ignored and the release edge stays at 13.
- Continuous assertion across a random RESET_REQ/START/SYNC_RST mix: CKE=1111 implies RESET_N=1111; OE always 1111; delay-line outputs always 0.

Source files
------------

// File: rtl/ddr3_reset_init_seq_pkg.sv
// Shared types and constants for the DDR3 reset/CKE init sequencer.
// Holds the state encoding, default cycle counts and lane words.
package ddr3_init_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RST_HOLD = 3'd1,
      ST_CKE_WAIT = 3'd2,
      ST_XPR_WAIT = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   localparam int unsigned DEF_RESET_CYCLES = 33300;
   localparam int unsigned DEF_CKE_CYCLES   = 83250;
   localparam int unsigned DEF_XPR_CYCLES   = 64;
   localparam int unsigned DEF_CNT_W        = 17;

   localparam logic [3:0] LANE_LO = 4'b0000;
   localparam logic [3:0] LANE_HI = 4'b1111;

   function automatic logic [3:0] lane(input logic hi);
      return hi ? LANE_HI : LANE_LO;
   endfunction

endpackage

// File: rtl/ddr3_reset_init_seq_if.sv
// Control interface between the memory controller and the init sequencer.
// master: drives start/reset_req pulses; slave: reports busy/init_done/state.
interface ddr3_init_ctrl_if;

   logic       start;
   logic       reset_req;
   logic       busy;
   logic       init_done;
   logic [2:0] state;

   modport master (
      output start,
      output reset_req,
      input  busy,
      input  init_done,
      input  state
   );

   modport slave (
      input  start,
      input  reset_req,
      output busy,
      output init_done,
      output state
   );

endinterface

// File: rtl/ddr3_reset_init_seq_timer.sv
// Shared state timer: cleared on load, counts while enabled.
// Ports: i_clk, i_rst, i_load, i_en, i_last (terminal value), o_tc.
module ddr3_init_timer #(
   parameter int unsigned CNT_W = 17
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_last,
   output logic             o_tc
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_load) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tc = i_en && (r_cnt == i_last);

endmodule

// File: rtl/ddr3_reset_init_seq.sv
// DDR3 power-up sequencer driving RESET_N/CKE serializer lane words.
// Ports: i_fab_clk, i_sync_rst, ctrl_if (slave), lane words, delay tie-offs.
module ddr3_reset_init_seq
   import ddr3_init_pkg::*;
#(
   parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
   parameter int unsigned CKE_CYCLES   = DEF_CKE_CYCLES,
   parameter int unsigned XPR_CYCLES   = DEF_XPR_CYCLES,
   parameter int unsigned CNT_W        = DEF_CNT_W
) (
   input  logic                i_fab_clk,
   input  logic                i_sync_rst,
   ddr3_init_ctrl_if.slave     ctrl_if,
   output logic [3:0]          o_reset_n_tx_data,
   output logic [3:0]          o_reset_n_oe_data,
   output logic [3:0]          o_cke_tx_data,
   output logic                o_reset_n_dly_move,
   output logic                o_reset_n_dly_dir,
   output logic                o_reset_n_dly_load
);

   state_t           r_state;
   state_t           w_next;
   logic [3:0]       r_rst_n;
   logic [3:0]       r_cke;
   logic             w_load;
   logic             w_en;
   logic             w_tc;
   logic [CNT_W-1:0] w_last;

   // Terminal value for the state currently being timed
   always_comb begin
      w_last = '0;
      w_en   = 1'b0;
      case (r_state)
         ST_RST_HOLD: begin
            w_last = CNT_W'(RESET_CYCLES - 1);
            w_en   = 1'b1;
         end
         ST_CKE_WAIT: begin
            w_last = CNT_W'(CKE_CYCLES - 1);
            w_en   = 1'b1;
         end
         ST_XPR_WAIT: begin
            w_last = CNT_W'(XPR_CYCLES - 1);
            w_en   = 1'b1;
         end
         default: begin
            w_last = '0;
            w_en   = 1'b0;
         end
      endcase
   end

   always_comb begin
      w_next = r_state;
      if (ctrl_if.reset_req) begin
         w_next = ST_RST_HOLD;
      end else begin
         case (r_state)
            ST_IDLE:     if (ctrl_if.start) w_next = ST_RST_HOLD;
            ST_RST_HOLD: if (w_tc) w_next = ST_CKE_WAIT;
            ST_CKE_WAIT: if (w_tc) w_next = ST_XPR_WAIT;
            ST_XPR_WAIT: if (w_tc) w_next = ST_DONE;
            ST_DONE:     w_next = ST_DONE;
            default:     w_next = ST_IDLE;
         endcase
      end
   end

   // reset_req in RST_HOLD keeps the state but must restart the hold
   assign w_load = ctrl_if.reset_req || (w_next != r_state);

   ddr3_init_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .i_clk  (i_fab_clk),
      .i_rst  (i_sync_rst),
      .i_load (w_load),
      .i_en   (w_en),
      .i_last (w_last),
      .o_tc   (w_tc)
   );

   // Lane words decoded from next state so they move with STATE
   always_ff @(posedge i_fab_clk) begin
      if (i_sync_rst) begin
         r_state <= ST_IDLE;
         r_rst_n <= LANE_LO;
         r_cke   <= LANE_LO;
      end else begin
         r_state <= w_next;
         r_rst_n <= lane((w_next == ST_CKE_WAIT) ||
                         (w_next == ST_XPR_WAIT) ||
                         (w_next == ST_DONE));
         r_cke   <= lane((w_next == ST_XPR_WAIT) ||
                         (w_next == ST_DONE));
      end
   end

   assign o_reset_n_tx_data  = r_rst_n;
   assign o_reset_n_oe_data  = LANE_HI;
   assign o_cke_tx_data      = r_cke;
   assign o_reset_n_dly_move = 1'b0;
   assign o_reset_n_dly_dir  = 1'b0;
   assign o_reset_n_dly_load = 1'b0;

   assign ctrl_if.busy      = w_en;
   assign ctrl_if.init_done = (r_state == ST_DONE);
   assign ctrl_if.state     = r_state;

endmodule

// File: tb/tb_ddr3_reset_init_seq.sv
// Self-checking bench for ddr3_reset_init_seq with small cycle counts.
// Reference model tracks elapsed cycles since the last sequence entry.
module tb_ddr3_reset_init_seq;

   localparam int R = 8;
   localparam int C = 12;
   localparam int X = 4;

   logic       clk;
   logic       sync_rst;
   logic [3:0] rstn_tx;
   logic [3:0] oe;
   logic [3:0] cke;
   logic       dmove;
   logic       ddir;
   logic       dload;

   int n_checks;
   int n_fail;
   int cyc;
   bit m_act;
   int m_k;

   ddr3_init_ctrl_if u_if ();

   ddr3_reset_init_seq #(
      .RESET_CYCLES (R),
      .CKE_CYCLES   (C),
      .XPR_CYCLES   (X),
      .CNT_W        (17)
   ) dut (
      .i_fab_clk          (clk),
      .i_sync_rst         (sync_rst),
      .ctrl_if            (u_if),
      .o_reset_n_tx_data  (rstn_tx),
      .o_reset_n_oe_data  (oe),
      .o_cke_tx_data      (cke),
      .o_reset_n_dly_move (dmove),
      .o_reset_n_dly_dir  (ddir),
      .o_reset_n_dly_load (dload)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   // Expected state from elapsed cycles since entering the hold
   function automatic int exp_state();
      int e;
      if (!m_act) return 0;
      e = cyc - m_k;
      if (e < R) return 1;
      if (e < R + C) return 2;
      if (e < R + C + X) return 3;
      return 4;
   endfunction

   task automatic check_model();
      int s;
      s = exp_state();
      chk("state", 32'(u_if.state), 32'(s));
      chk("rst_n", 32'(rstn_tx), (s >= 2) ? 32'hF : 32'h0);
      chk("cke", 32'(cke), (s >= 3) ? 32'hF : 32'h0);
      chk("busy", 32'(u_if.busy), 32'((s >= 1) && (s <= 3)));
      chk("done", 32'(u_if.init_done), 32'(s == 4));
      chk("oe", 32'(oe), 32'hF);
      chk("dly", {29'd0, dmove, ddir, dload}, 32'd0);
      chk("inv", 32'((cke == 4'hF) && (rstn_tx == 4'h0)), 32'd0);
   endtask

   task automatic step(input logic rst, input logic st, input logic rq);
      @(negedge clk);
      sync_rst      = rst;
      u_if.start     = st;
      u_if.reset_req = rq;
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_act = 1'b0;
      end else if (rq) begin
         m_act = 1'b1;
         m_k   = cyc;
      end else if (st && !m_act) begin
         m_act = 1'b1;
         m_k   = cyc;
      end
      #1;
      check_model();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      m_act    = 1'b0;
      m_k      = 0;
      sync_rst      = 1'b1;
      u_if.start     = 1'b0;
      u_if.reset_req = 1'b0;

      // Power-on reset and a few idle cycles
      repeat (3) step(1'b1, 1'b0, 1'b0);
      chk("por_state", 32'(u_if.state), 32'd0);
      chk("por_rstn", 32'(rstn_tx), 32'h0);
      repeat (5) step(1'b0, 1'b0, 1'b0);

      // Nominal sequence
      step(1'b0, 1'b1, 1'b0);
      chk("nom_st1", 32'(u_if.state), 32'd1);
      chk("nom_busy", 32'(u_if.busy), 32'd1);
      for (int i = 1; i <= R + C + X + 4; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (i == R - 1) chk("nom_rlo", 32'(rstn_tx), 32'h0);
         if (i == R) chk("nom_rhi", 32'(rstn_tx), 32'hF);
         if (i == R + C - 1) chk("nom_clo", 32'(cke), 32'h0);
         if (i == R + C) chk("nom_chi", 32'(cke), 32'hF);
         if (i == R + C + X - 1) chk("nom_busy_end", 32'(u_if.busy), 32'd1);
         if (i == R + C + X) chk("nom_done", 32'(u_if.init_done), 32'd1);
      end

      // SYNC_RST in DONE
      repeat (3) step(1'b1, 1'b0, 1'b0);
      chk("rst_st", 32'(u_if.state), 32'd0);
      chk("rst_cke", 32'(cke), 32'h0);
      chk("rst_done", 32'(u_if.init_done), 32'd0);
      step(1'b0, 1'b0, 1'b0);

      // RESET_REQ during CKE_WAIT
      step(1'b0, 1'b1, 1'b0);
      repeat (14) step(1'b0, 1'b0, 1'b0);
      chk("ckw_pre", 32'(u_if.state), 32'd2);
      step(1'b0, 1'b0, 1'b1);
      chk("ckw_st", 32'(u_if.state), 32'd1);
      chk("ckw_rlo", 32'(rstn_tx), 32'h0);
      for (int i = 1; i <= R; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (i == R - 1) chk("ckw_still_lo", 32'(rstn_tx), 32'h0);
         if (i == R) chk("ckw_rhi", 32'(rstn_tx), 32'hF);
         if (i == R) chk("ckw_cke", 32'(cke), 32'h0);
      end
      repeat (3) step(1'b1, 1'b0, 1'b0);

      // RESET_REQ during RST_HOLD restarts the hold
      step(1'b0, 1'b1, 1'b0);
      repeat (4) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= R; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (i == R - 1) chk("rh_lo", 32'(rstn_tx), 32'h0);
         if (i == R) chk("rh_hi", 32'(rstn_tx), 32'hF);
      end
      repeat (3) step(1'b1, 1'b0, 1'b0);

      // START with RESET_REQ, then stray START
      step(1'b0, 1'b1, 1'b1);
      chk("sr_st", 32'(u_if.state), 32'd1);
      repeat (2) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      for (int i = 4; i <= R; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (i == R - 1) chk("sr_lo", 32'(rstn_tx), 32'h0);
         if (i == R) chk("sr_hi", 32'(rstn_tx), 32'hF);
      end

      // Random mix against the model
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(199) == 0),
              ($urandom_range(19) == 0),
              ($urandom_range(149) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
